// File: rtl/bcd_div3_stream_ctrl.sv
// bcd_div3_stream_ctrl
// Digit-serial BCD divisibility-by-3 checker. It accepts one BCD digit per
// cycle over a valid/ready handshake and keeps the running digit-sum residue
// mod 3. It then holds a registered verdict until the consumer takes it.
// Optional feature macro: DIV9_CHECK_EN adds a mod-9 residue and drives
// is_div9_o. Without the macro, is_div9_o is tied low.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_ACCEPT | taking digits, residues and count accumulate
// ST_REPORT | verdict presented and held, digits refused
module bcd_div3_stream_ctrl #(
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             digit_valid_i,
    output logic             digit_ready_o,
    input  logic [3:0]       digit_i,
    input  logic             digit_last_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             is_divider_o,
    output logic             is_div_by9_o,
    output logic             is_error_o,
    output logic [CNT_W-1:0] digit_count_o
);

    typedef enum logic {ST_ACCEPT = 1'b0, ST_REPORT = 1'b1} state_e;

    state_e           state_q;
    logic [1:0]       r3_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic             ready_q;
    logic             valid_q;
    logic             div3_q;
    logic             err_out_q;

    logic [1:0]       d3;
    logic [2:0]       sum3;
    logic [1:0]       r3_d;
    logic [CNT_W-1:0] count_d;
    logic             hit_max;
    logic             err_d;
    logic             xfer;
    logic             finish;

    // Fold the incoming digit to mod 3 so the update is one add plus a conditional subtract.
    always_comb begin
        d3 = 2'd0;
        case (digit_i)
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13: d3 = 2'd1;
            4'd2, 4'd5, 4'd8, 4'd11, 4'd14: d3 = 2'd2;
            default:                        d3 = 2'd0;
        endcase
        sum3    = {1'b0, r3_q} + {1'b0, d3};
        r3_d    = (sum3 >= 3'd3) ? 2'(sum3 - 3'd3) : sum3[1:0];
        count_d = count_q + CNT_W'(1);
        hit_max = (count_d == CNT_W'(MAX_DIGITS));
        xfer    = digit_valid_i & ready_q & (state_q == ST_ACCEPT);
        finish  = xfer & (digit_last_i | hit_max);
        // Reaching the digit limit without a last marker counts as overflow.
        err_d   = err_q | (digit_i > 4'd9) | (hit_max & ~digit_last_i);
    end

    // Main sequencer: accumulate in ACCEPT, register and hold the verdict in REPORT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ACCEPT;
            r3_q      <= 2'd0;
            count_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            div3_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (xfer) begin
                        r3_q    <= r3_d;
                        count_q <= count_d;
                        err_q   <= err_d;
                        if (finish) begin
                            state_q   <= ST_REPORT;
                            ready_q   <= 1'b0;
                            valid_q   <= 1'b1;
                            div3_q    <= (r3_d == 2'd0) & ~err_d;
                            err_out_q <= err_d;
                        end
                    end
                end
                ST_REPORT: begin
                    if (result_ready_i) begin
                        state_q   <= ST_ACCEPT;
                        r3_q      <= 2'd0;
                        count_q   <= '0;
                        err_q     <= 1'b0;
                        ready_q   <= 1'b1;
                        valid_q   <= 1'b0;
                        div3_q    <= 1'b0;
                        err_out_q <= 1'b0;
                    end
                end
                default: state_q <= ST_ACCEPT;
            endcase
        end
    end

`ifdef DIV9_CHECK_EN
    logic [3:0] r9_q;
    logic [3:0] d9;
    logic [4:0] sum9;
    logic [3:0] r9_d;
    logic       div9_q;

    // Digits above 9 only need one fold to land in 0..8; such numbers are masked by the error anyway.
    always_comb begin
        d9   = (digit_i >= 4'd9) ? (digit_i - 4'd9) : digit_i;
        sum9 = {1'b0, r9_q} + {1'b0, d9};
        r9_d = (sum9 >= 5'd9) ? 4'(sum9 - 5'd9) : sum9[3:0];
    end

    // Mod-9 residue and its verdict follow the same timing and hold rules as the mod-3 path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r9_q   <= 4'd0;
            div9_q <= 1'b0;
        end else if (xfer) begin
            r9_q <= r9_d;
            if (finish) begin
                div9_q <= (r9_d == 4'd0) & ~err_d;
            end
        end else if ((state_q == ST_REPORT) && result_ready_i) begin
            r9_q   <= 4'd0;
            div9_q <= 1'b0;
        end
    end

    assign is_div_by9_o = div9_q;
`else
    assign is_div_by9_o = 1'b0;
`endif

    assign digit_ready_o  = ready_q;
    assign result_valid_o = valid_q;
    assign is_divider_o   = div3_q;
    assign is_error_o     = err_out_q;
    assign digit_count_o  = count_q;

endmodule

// File: tb/tb_bcd_div3_stream_ctrl.sv
// Bench for bcd_div3_stream_ctrl. A transaction-level model keeps the plain
// integer digit sum of the current number. A negedge process compares the
// DUT with that model every cycle. Directed tests also pin literal values.
module tb_bcd_div3_stream_ctrl;
    localparam int MAXD = 8;
    localparam int CW   = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          digit_valid_i = 1'b0;
    logic          digit_ready_o;
    logic [3:0]    digit_i = 4'd0;
    logic          digit_last_i = 1'b0;
    logic          result_valid_o;
    logic          result_ready_i = 1'b1;
    logic          is_divider_o;
    logic          is_div_by9_o;
    logic          is_error_o;
    logic [CW-1:0] digit_count_o;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    bcd_div3_stream_ctrl #(.MAX_DIGITS(MAXD), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .digit_valid_i(digit_valid_i), .digit_ready_o(digit_ready_o),
        .digit_i(digit_i), .digit_last_i(digit_last_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .is_divider_o(is_divider_o), .is_div_by9_o(is_div_by9_o),
        .is_error_o(is_error_o), .digit_count_o(digit_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one number is a list of digits summed as an integer.
    bit m_accept = 1'b1;
    int m_sum = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_accept = 1'b1; m_sum = 0; m_cnt = 0; m_err = 1'b0;
        end else if (!m_accept) begin
            if (result_ready_i) begin
                m_accept = 1'b1; m_sum = 0; m_cnt = 0; m_err = 1'b0;
            end
        end else if (digit_valid_i) begin
            m_sum += int'(digit_i);
            m_cnt++;
            if (digit_i > 9) m_err = 1'b1;
            if (digit_last_i || m_cnt == MAXD) begin
                if (!digit_last_i) m_err = 1'b1;
                m_accept = 1'b0;
            end
        end
    end

    function automatic int exp_div9();
`ifdef DIV9_CHECK_EN
        return int'(!m_accept && (m_sum % 9 == 0) && !m_err);
`else
        return 0;
`endif
    endfunction

    always @(negedge clk_i) begin
        if (run) begin
            check("mdl_ready", int'(digit_ready_o), int'(m_accept));
            check("mdl_valid", int'(result_valid_o), int'(!m_accept));
            check("mdl_div3", int'(is_divider_o), int'(!m_accept && (m_sum % 3 == 0) && !m_err));
            check("mdl_div9", int'(is_div_by9_o), exp_div9());
            check("mdl_err", int'(is_error_o), int'(!m_accept && m_err));
            check("mdl_count", int'(digit_count_o), m_cnt);
        end
    end

    task automatic step(input logic v, input logic [3:0] d, input logic l);
        digit_valid_i = v;
        digit_i       = d;
        digit_last_i  = l;
        @(negedge clk_i);
    endtask

    task automatic verdict(input string tag, input int v, input int dv, input int er, input int cnt);
        check({tag, "_valid"}, int'(result_valid_o), v);
        check({tag, "_div3"},  int'(is_divider_o), dv);
        check({tag, "_err"},   int'(is_error_o), er);
        check({tag, "_count"}, int'(digit_count_o), cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_ready", int'(digit_ready_o), 1);
        verdict("rst", 0, 0, 0, 0);
        check("rst_div9", int'(is_div_by9_o), 0);
        rst_ni = 1'b1;
        run = 1'b1;
        step(0, 0, 0);

        // 1,2,3 -> divisible, verdict one cycle after the last digit
        step(1, 4'd1, 0); step(1, 4'd2, 0); step(1, 4'd3, 1);
        verdict("t1", 1, 1, 0, 3);
        check("t1_ready", int'(digit_ready_o), 0);
        step(0, 0, 0);
        check("t1_after_ready", int'(digit_ready_o), 1);
        check("t1_after_valid", int'(result_valid_o), 0);

        // 1,2,4 -> not divisible; a digit held during REPORT is ignored, next number starts right after
        step(1, 4'd1, 0); step(1, 4'd2, 0); step(1, 4'd4, 1);
        verdict("t2", 1, 0, 0, 3);
        step(1, 4'd7, 0);
        check("t2_hs_ready", int'(digit_ready_o), 1);
        check("t2_hs_count", int'(digit_count_o), 0);
        step(1, 4'd6, 1);
        verdict("t2_next", 1, 1, 0, 1);
        step(0, 0, 0);

        // illegal digit 0xA
        step(1, 4'd5, 0); step(1, 4'hA, 0); step(1, 4'd1, 1);
        verdict("t3", 1, 0, 1, 3);
        step(0, 0, 0);

        // eight 3s, no last -> overflow; then with last on the 8th -> legal
        for (int i = 0; i < MAXD; i++) step(1, 4'd3, 0);
        verdict("t4_ovf", 1, 0, 1, 8);
        step(0, 0, 0);
        for (int i = 0; i < MAXD; i++) step(1, 4'd3, (i == MAXD - 1));
        verdict("t4_ok", 1, 1, 0, 8);
        check("t4_ok_div9", int'(is_div_by9_o), 0);
        step(0, 0, 0);

        // hold verdict for 5 cycles with digit pulses ignored
        result_ready_i = 1'b0;
        step(1, 4'd3, 0); step(1, 4'd6, 1);
        for (int i = 0; i < 5; i++) begin
            step((i % 2) == 0, 4'd1, 1'b1);
            verdict("t5_hold", 1, 1, 0, 2);
            check("t5_hold_ready", int'(digit_ready_o), 0);
        end
        result_ready_i = 1'b1;
        step(0, 0, 0);
        verdict("t5_rel", 0, 0, 0, 0);

        // reset mid-number
        step(1, 4'd1, 0); step(1, 4'd2, 0);
        digit_valid_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        verdict("t5_rst", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(0, 0, 0);
        check("t5_rst_ready", int'(digit_ready_o), 1);
        check("t5_rst_count", int'(digit_count_o), 0);

        // mod-9 path
        step(1, 4'd9, 0); step(1, 4'd9, 1);
        verdict("t6_99", 1, 1, 0, 2);
`ifdef DIV9_CHECK_EN
        check("t6_99_div9", int'(is_div_by9_o), 1);
`else
        check("t6_99_div9", int'(is_div_by9_o), 0);
`endif
        step(0, 0, 0);
        step(1, 4'd3, 0); step(1, 4'd3, 1);
        verdict("t6_33", 1, 1, 0, 2);
        check("t6_33_div9", int'(is_div_by9_o), 0);
        step(0, 0, 0);
        step(0, 0, 0);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
